s_mem_phase_controller: RTL and testbench
=========================================

Name: s_mem_phase_controller

Overview:
- Sequences one RC4 key trial across three phases on the single-port 256x8 S memory: init (s[i]=i), shuffle (key schedule), then decrypt.
- Arbitrates the S-memory address, write-data and write-enable lines so that only the active phase FSM drives the RAM.
- Issues per-phase start pulses and a sub-FSM reset, and runs a per-phase watchdog.
- Sits between the top-level key-search loop and the init, shuffle and decrypt FSMs plus the S RAM.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles allowed in any one run phase before ERROR (the shuffle phase needs about 3072)
CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a trial; accepted only in IDLE, DONE or ERROR
sub_reset  out  1  one-cycle reset to init/shuffle/decrypt FSMs (returns them to IDLE)
init_start  out  1  one-cycle start to init FSM
shuffle_start  out  1  one-cycle start to shuffle FSM
decrypt_start  out  1  one-cycle start to decrypt FSM
init_done  in  1  level, init FSM finished
shuffle_finished  in  1  level, shuffle FSM finished
decrypt_done  in  1  level, decrypt FSM finished
init_addr / shuf_addr / dec_addr  in  8 each  requester addresses
init_data / shuf_data / dec_data  in  8 each  requester write data
init_wren / shuf_wren / dec_wren  in  1 each  requester write enables
s_address  out  8  to S RAM
s_data  out  8  to S RAM
s_wren  out  1  to S RAM
phase  out  2  current owner: 0 none, 1 init, 2 shuffle, 3 decrypt
busy  out  1  high from start acceptance until DONE or ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR

Behaviour:
- Reset (synchronous, active-high): state IDLE, phase=0, all start pulses 0, sub_reset 0, busy/done/error 0, watchdog 0, s_wren 0, s_address 0, s_data 0.
- Reset mid-trial aborts immediately with the same values. The sub-FSMs are not reset by this block on global reset; they share the same global reset.
- States and transitions:
  - IDLE: on start -> CLEAR.
  - CLEAR: sub_reset=1 for exactly this cycle -> INIT_GO.
  - INIT_GO: init_start=1, phase=1 -> INIT_RUN.
  - INIT_RUN: init_done -> SHUF_GO.
  - SHUF_GO: shuffle_start=1, phase=2 -> SHUF_RUN.
  - SHUF_RUN: shuffle_finished -> DEC_GO.
  - DEC_GO: decrypt_start=1, phase=3 -> DEC_RUN.
  - DEC_RUN: decrypt_done -> DONE.
  - DONE: done=1, phase=0; on start -> CLEAR.
  - ERROR: error=1, phase=0; on start -> CLEAR.
- The sub_reset step is mandatory: the shuffle FSM holds FINISH until reset, so every trial begins with CLEAR.
- start is ignored in all other states; no queuing.
- Done inputs are sampled only in their own RUN state. A done level left over from a previous phase has no effect.
- Watchdog:
  - Cleared on entry to each GO state and incremented every RUN cycle.
  - If it reaches TIMEOUT_CYCLES in any RUN state without that phase's done -> ERROR.
  - If done and timeout coincide in the same cycle, done wins.
- Arbitration:
  - s_address, s_data and s_wren are a combinational mux selected by the registered phase, so there is no added latency.
  - When phase=0, s_wren=0 and address/data=0.
  - Non-owner wren is always suppressed. Non-owner address and data are ignored.
- busy = state not in {IDLE, DONE, ERROR}.
- phase is updated in the GO state, so the owner is granted the bus in the same cycle its start pulse is seen.

Decomposition:
- Shared package rc4_pkg holds:
  - phase_t enum (PH_NONE, PH_INIT, PH_SHUF, PH_DEC);
  - ctrl_state_t enum;
  - S_ADDR_W=8 and S_DATA_W=8.
- One natural sub-module, s_mem_mux: a purely combinational 3:1 bus mux keyed by phase_t.
- FSM and watchdog stay in the top.

Test Plan:
- Reset, then a start pulse with done inputs tied high after 10 cycles each. Expect: sub_reset at cycle 1, init_start at cycle 2, phase sequence 1->2->3, done=1, busy=0.
- With phase=2, drive shuf_addr=0x5A, shuf_data=0x3C, shuf_wren=1 and init_wren=1. Expect s_address=0x5A, s_data=0x3C, s_wren=1 in the same cycle.
- Hold shuffle_finished=0 with TIMEOUT_CYCLES=16. Expect error=1 exactly 16 cycles after SHUF_RUN entry, and s_wren=0 from then on.
- Pulse start while in SHUF_RUN. Expect no sub_reset and no state change. Pulse start in DONE. Expect sub_reset the next cycle.
- Assert reset during DEC_RUN. Expect phase=0, busy=0, s_wren=0 on the next edge.
- Assert shuffle_finished in the same cycle the watchdog hits its limit. Expect DEC_GO, not ERROR.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and widths for the RC4 S-memory phase controller
// Contents: phase_t bus owner, ctrl_state_t controller states, S memory widths,
//           phase_of (bus owner for a state), is_run (watchdog-active state)
package rc4_pkg;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;
    typedef enum logic [1:0] {PH_NONE, PH_INIT, PH_SHUF, PH_DEC} phase_t;
    typedef enum logic [3:0] {
        ST_IDLE, ST_CLEAR, ST_INIT_GO, ST_INIT_RUN, ST_SHUF_GO,
        ST_SHUF_RUN, ST_DEC_GO, ST_DEC_RUN, ST_DONE, ST_ERROR
    } ctrl_state_t;
    function automatic phase_t phase_of(ctrl_state_t s);
        return (s == ST_INIT_GO || s == ST_INIT_RUN) ? PH_INIT :
               (s == ST_SHUF_GO || s == ST_SHUF_RUN) ? PH_SHUF :
               (s == ST_DEC_GO  || s == ST_DEC_RUN)  ? PH_DEC  : PH_NONE;
    endfunction
    function automatic logic is_run(ctrl_state_t s);
        return s == ST_INIT_RUN || s == ST_SHUF_RUN || s == ST_DEC_RUN;
    endfunction
endpackage

// File: rtl/s_mem_mux.sv
// s_mem_mux: combinational 3:1 S-memory bus mux keyed by the owning phase
// Ports: phase (owner select), init_/shuf_/dec_ addr/data/wren (requesters),
//        s_address/s_data/s_wren (to S RAM; all zero when no owner)
module s_mem_mux
    import rc4_pkg::*;
(
    input  phase_t              phase,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_data,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] shuf_addr,
    input  logic [S_DATA_W-1:0] shuf_data,
    input  logic                shuf_wren,
    input  logic [S_ADDR_W-1:0] dec_addr,
    input  logic [S_DATA_W-1:0] dec_data,
    input  logic                dec_wren,
    output logic [S_ADDR_W-1:0] s_address,
    output logic [S_DATA_W-1:0] s_data,
    output logic                s_wren
);
    always_comb begin
        s_address = phase == PH_INIT ? init_addr : phase == PH_SHUF ? shuf_addr : phase == PH_DEC ? dec_addr : '0;
        s_data    = phase == PH_INIT ? init_data : phase == PH_SHUF ? shuf_data : phase == PH_DEC ? dec_data : '0;
        s_wren    = phase == PH_INIT ? init_wren : phase == PH_SHUF ? shuf_wren : phase == PH_DEC ? dec_wren : 1'b0;
    end
endmodule

// File: rtl/s_mem_phase_controller.sv
// s_mem_phase_controller: sequences init/shuffle/decrypt over the shared S RAM for one RC4 key trial
// Ports: CLOCK_50, reset (sync, active-high); start (trial request);
//        sub_reset, init_start, shuffle_start, decrypt_start (one-cycle pulses to sub-FSMs);
//        init_done, shuffle_finished, decrypt_done (sub-FSM completion levels);
//        init_/shuf_/dec_ addr/data/wren (requester buses); s_address/s_data/s_wren (S RAM);
//        phase (bus owner), busy, done, error (trial status)
module s_mem_phase_controller
    import rc4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    output logic                sub_reset,
    output logic                init_start,
    output logic                shuffle_start,
    output logic                decrypt_start,
    input  logic                init_done,
    input  logic                shuffle_finished,
    input  logic                decrypt_done,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_data,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] shuf_addr,
    input  logic [S_DATA_W-1:0] shuf_data,
    input  logic                shuf_wren,
    input  logic [S_ADDR_W-1:0] dec_addr,
    input  logic [S_DATA_W-1:0] dec_data,
    input  logic                dec_wren,
    output logic [S_ADDR_W-1:0] s_address,
    output logic [S_DATA_W-1:0] s_data,
    output logic                s_wren,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                done,
    output logic                error
);
    ctrl_state_t      state, state_nx;
    phase_t           phase_q;
    logic [CNT_W-1:0] wdog;
    logic             timeout;

    // wdog counts completed RUN cycles, so the last allowed RUN cycle holds TIMEOUT_CYCLES-1
    assign timeout = wdog == CNT_W'(TIMEOUT_CYCLES - 1);
    assign phase   = phase_q;

    // phase is registered from the next state so the owner holds the bus during its GO cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase_q <= PH_NONE;
            wdog    <= '0;
        end else begin
            state   <= state_nx;
            phase_q <= phase_of(state_nx);
            wdog    <= is_run(state) ? wdog + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: state_nx = start ? ST_CLEAR : state;
            ST_CLEAR:    state_nx = ST_INIT_GO;
            ST_INIT_GO:  state_nx = ST_INIT_RUN;
            ST_INIT_RUN: state_nx = init_done ? ST_SHUF_GO : timeout ? ST_ERROR : state;
            ST_SHUF_GO:  state_nx = ST_SHUF_RUN;
            ST_SHUF_RUN: state_nx = shuffle_finished ? ST_DEC_GO : timeout ? ST_ERROR : state;
            ST_DEC_GO:   state_nx = ST_DEC_RUN;
            ST_DEC_RUN:  state_nx = decrypt_done ? ST_DONE : timeout ? ST_ERROR : state;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        sub_reset     = state == ST_CLEAR;
        init_start    = state == ST_INIT_GO;
        shuffle_start = state == ST_SHUF_GO;
        decrypt_start = state == ST_DEC_GO;
        done          = state == ST_DONE;
        error         = state == ST_ERROR;
        busy          = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    end

    s_mem_mux u_mux (
        .phase     (phase_q),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .shuf_addr (shuf_addr),
        .shuf_data (shuf_data),
        .shuf_wren (shuf_wren),
        .dec_addr  (dec_addr),
        .dec_data  (dec_data),
        .dec_wren  (dec_wren),
        .s_address (s_address),
        .s_data    (s_data),
        .s_wren    (s_wren)
    );
endmodule

// File: tb/tb_s_mem_phase_controller.sv
// tb_s_mem_phase_controller: random trials checked against a per-trial timeline model
module tb_s_mem_phase_controller;
    localparam int T = 16;
    localparam int NEVER = 32'h3fff_ffff;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1, start = 1'b0;
    logic sub_reset, init_start, shuffle_start, decrypt_start;
    logic init_done = 1'b0, shuffle_finished = 1'b0, decrypt_done = 1'b0;
    logic [7:0] init_addr = '0, init_data = '0, shuf_addr = '0, shuf_data = '0, dec_addr = '0, dec_data = '0;
    logic init_wren = 1'b0, shuf_wren = 1'b0, dec_wren = 1'b0;
    logic [7:0] s_address, s_data;
    logic s_wren, busy, done, error;
    logic [1:0] phase;

    always #5 CLOCK_50 = ~CLOCK_50;

    s_mem_phase_controller #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .sub_reset(sub_reset), .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
        .init_done(init_done), .shuffle_finished(shuffle_finished), .decrypt_done(decrypt_done),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
        .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
        .phase(phase), .busy(busy), .done(done), .error(error)
    );

    int vectors = 0, miscompares = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Trial timeline: start seen in cycle t0, CLEAR at t0+1, INIT_GO at t0+2,
    // each RUN begins the cycle after its GO and lasts len cycles (err when it timed out).
    bit tv = 0;
    int t0, a, li, b, ls, c, ld;
    bit ei, es, ed;
    int ri = NEVER, rs = NEVER, rd = NEVER;

    // A RUN starting at s ends when its done level (high from cycle rise on) is first
    // seen within T cycles; seeing it in the final cycle still counts as done.
    function automatic void run_len(input int s, input int rise, output int len, output bit err);
        int k = rise > s ? rise - s : 0;
        err = k > T - 1;
        len = err ? T : k + 1;
    endfunction

    function automatic int ofs();
        return int'($urandom_range(0, 22)) - 3;
    endfunction

    task automatic accept(input int n);
        tv = 1; t0 = n;
        a = t0 + 3; ri = a + ofs(); run_len(a, ri, li, ei);
        b = a + li + 1; rs = b + ofs(); run_len(b, rs, ls, es);
        c = b + ls + 1; rd = c + ofs(); run_len(c, rd, ld, ed);
    endtask

    // {sub_reset, init_start, shuffle_start, decrypt_start, busy, done, error, phase[1:0]}
    function automatic logic [8:0] exp_ctrl(input int n);
        if (!tv) return 9'b0_000_000_00;
        if (n == t0 + 1) return 9'b1_000_100_00;
        if (n == t0 + 2) return 9'b0_100_100_01;
        if (n < a + li)  return 9'b0_000_100_01;
        if (ei)          return 9'b0_000_001_00;
        if (n == a + li) return 9'b0_010_100_10;
        if (n < b + ls)  return 9'b0_000_100_10;
        if (es)          return 9'b0_000_001_00;
        if (n == b + ls) return 9'b0_001_100_11;
        if (n < c + ld)  return 9'b0_000_100_11;
        return ed ? 9'b0_000_001_00 : 9'b0_000_010_00;
    endfunction

    function automatic logic [16:0] exp_bus(input logic [1:0] p);
        case (p)
            2'd1:    return {init_addr, init_data, init_wren};
            2'd2:    return {shuf_addr, shuf_data, shuf_wren};
            2'd3:    return {dec_addr, dec_data, dec_wren};
            default: return 17'd0;
        endcase
    endfunction

    initial begin
        logic [8:0] e;
        for (int i = 0; i < 4000; i++) begin
            @(posedge CLOCK_50);
            cyc++;
            #1;
            reset = cyc <= 2 || $urandom_range(0, 299) == 0;
            start = !reset && $urandom_range(0, 7) == 0;
            init_done        = cyc >= ri;
            shuffle_finished = cyc >= rs;
            decrypt_done     = cyc >= rd;
            {init_addr, init_data, init_wren} = 17'($urandom);
            {shuf_addr, shuf_data, shuf_wren} = 17'($urandom);
            {dec_addr, dec_data, dec_wren}    = 17'($urandom);
            @(negedge CLOCK_50);
            e = exp_ctrl(cyc);
            check(tv ? "ctrl" : "idle_ctrl",
                  32'({sub_reset, init_start, shuffle_start, decrypt_start, busy, done, error, phase}), 32'(e));
            check(tv ? "bus" : "idle_bus", 32'({s_address, s_data, s_wren}), 32'(exp_bus(e[1:0])));
            if (reset) tv = 0;
            else if (start && !e[4]) accept(cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
